// File: rtl/mdu_hilo_pkg.sv
// Shared constants and FSM state encoding for the HI/LO multiply/divide unit.
package mdu_hilo_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;
endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);
  assign o_val = i_neg ? ((~i_val) + {{(W-1){1'b0}}, 1'b1}) : i_val;
endmodule

// File: rtl/mdu_hilo.sv
// Iterative radix-2 shift-add multiplier / restoring divider owning the HI/LO registers.
module mdu_hilo
  import mdu_hilo_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             DIV_START,
  input  logic             SIGNED,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_lo_write_en,
  input  logic             hi_lo_reg_control,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             BUSY,
  output logic             DONE,
  output logic             divide_zero
);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic               r_op_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  mdu_sign_fix #(.W(WIDTH)) u_mag_a (
    .i_val(A), .i_neg(SIGNED & A[WIDTH-1]), .o_val(w_a_mag)
  );
  mdu_sign_fix #(.W(WIDTH)) u_mag_b (
    .i_val(B), .i_neg(SIGNED & B[WIDTH-1]), .o_val(w_b_mag)
  );
  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_neg_res), .o_val(w_prod_fix)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_res), .o_val(w_quo_fix)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_rem), .o_val(w_rem_fix)
  );

  // Multiply step: r_acc = {partial product, remaining multiplier bits}, shifted right each edge.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: r_acc = {remainder, dividend/quotient}; the shifted remainder never exceeds 2*divisor.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opb};

  // Restore on borrow, otherwise keep the difference and shift in a 1 quotient bit.
  always_comb begin
    w_div_next = {2*WIDTH{1'b0}};
    if (w_div_diff[WIDTH]) begin
      w_div_next = {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  assign w_acc_next = (r_state == ST_DIV) ? w_div_next : w_mul_next;

  // Control FSM, iteration counter, datapath accumulator and HI/LO registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_acc     <= {2*WIDTH{1'b0}};
      r_opb     <= {WIDTH{1'b0}};
      r_op_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (hi_lo_write_en) begin
            if (hi_lo_reg_control) r_hi <= A;
            else                   r_lo <= A;
          end
          if (START) begin
            r_acc     <= {{WIDTH{1'b0}}, w_b_mag};
            r_opb     <= w_a_mag;
            r_op_div  <= 1'b0;
            r_neg_res <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_rem <= SIGNED & A[WIDTH-1];
            r_cnt     <= {CNT_W{1'b0}};
            r_busy    <= 1'b1;
            r_state   <= ST_MUL;
          end else if (DIV_START) begin
            if (B == {WIDTH{1'b0}}) begin
              r_dz <= 1'b1;
            end else begin
              r_acc     <= {{WIDTH{1'b0}}, w_a_mag};
              r_opb     <= w_b_mag;
              r_op_div  <= 1'b1;
              r_neg_res <= SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
              r_neg_rem <= SIGNED & A[WIDTH-1];
              r_cnt     <= {CNT_W{1'b0}};
              r_busy    <= 1'b1;
              r_state   <= ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_op_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= {CNT_W{1'b0}};
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign HI          = r_hi;
  assign LO          = r_lo;
  assign BUSY        = r_busy;
  assign DONE        = r_done;
  assign divide_zero = r_dz;
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed and randomized checks of mdu_hilo against an arithmetic reference model.
module tb_mdu_hilo;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        DIV_START = 1'b0;
  logic        SIGNED = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        hi_lo_write_en = 1'b0;
  logic        hi_lo_reg_control = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        BUSY;
  logic        DONE;
  logic        divide_zero;

  int total = 0;
  int bad   = 0;

  mdu_hilo dut (
    .CLK(CLK), .RST(RST), .START(START), .DIV_START(DIV_START), .SIGNED(SIGNED),
    .A(A), .B(B), .hi_lo_write_en(hi_lo_write_en), .hi_lo_reg_control(hi_lo_reg_control),
    .HI(HI), .LO(LO), .BUSY(BUSY), .DONE(DONE), .divide_zero(divide_zero)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: {HI, LO} from plain 64-bit arithmetic; SV division truncates toward zero.
  function automatic logic [63:0] model(input bit isdiv, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    if (!isdiv) r = sa * sb;
    else        r = {32'(sa % sb), 32'(sa / sb)};
    return r;
  endfunction

  // mode 1: START/mthi pulses at iteration 5; mode 2: mthi together with the request.
  task automatic run_op(input string tag, input bit isdiv, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input int mode, input logic [63:0] exp);
    int k;
    int busy_n;
    START = !isdiv; DIV_START = isdiv; SIGNED = sgn; A = a; B = b;
    hi_lo_write_en = (mode == 2); hi_lo_reg_control = 1'b1;
    tick();
    START = 1'b0; DIV_START = 1'b0; hi_lo_write_en = 1'b0;
    A = $urandom; B = $urandom; SIGNED = 1'($urandom);
    chk({tag, "_busy_e0"}, 64'(BUSY), 64'd1);
    busy_n = 1;
    for (k = 1; k <= 40; k++) begin
      if (mode == 1 && k == 5) begin
        START = 1'b1; DIV_START = 1'b1; hi_lo_write_en = 1'b1;
        hi_lo_reg_control = 1'($urandom);
      end
      tick();
      START = 1'b0; DIV_START = 1'b0; hi_lo_write_en = 1'b0;
      if (DONE) break;
      if (BUSY) busy_n++;
    end
    chk({tag, "_latency"}, 64'(k), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(BUSY), 64'd0);
    chk({tag, "_hi"}, 64'(HI), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(LO), 64'(exp[31:0]));
    tick();
    chk({tag, "_done_pulse"}, 64'(DONE), 64'd0);
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] v);
    hi_lo_write_en = 1'b1; hi_lo_reg_control = to_hi; A = v;
    tick();
    hi_lo_write_en = 1'b0;
  endtask

  initial begin
    bit          isdiv;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          saw_done;

    #12;
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_flags", 64'({DONE, divide_zero}), 64'd0);
    RST = 1'b1;
    tick();

    run_op("multu_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 64'hFFFFFFFE_00000001);
    run_op("mult_neg3x7", 1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 0, 64'hFFFFFFFF_FFFFFFEB);
    run_op("div_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu_7_2", 1'b1, 1'b0, 32'd7, 32'd2, 0, 64'h00000001_00000003);
    run_op("div_min_m1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 64'h00000000_80000000);

    mt(1'b1, 32'h11);
    mt(1'b0, 32'h22);
    DIV_START = 1'b1; SIGNED = 1'b1; A = 32'h55; B = 32'h0;
    tick();
    DIV_START = 1'b0;
    chk("dz_pulse", 64'(divide_zero), 64'd1);
    chk("dz_busy", 64'(BUSY), 64'd0);
    tick();
    chk("dz_pulse_end", 64'(divide_zero), 64'd0);
    chk("dz_no_busy_done", 64'({BUSY, DONE}), 64'd0);
    chk("dz_hi", 64'(HI), 64'h11);
    chk("dz_lo", 64'(LO), 64'h22);

    mt(1'b1, 32'h1234);
    mt(1'b0, 32'h5678);
    chk("mthi", 64'(HI), 64'h1234);
    chk("mtlo", 64'(LO), 64'h5678);
    run_op("multu_ignore", 1'b0, 1'b0, 32'h0001_2345, 32'h0000_6789, 1,
           model(1'b0, 1'b0, 32'h0001_2345, 32'h0000_6789));
    run_op("mthi_with_start", 1'b0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 2,
           model(1'b0, 1'b1, 32'h8000_0001, 32'h7FFF_FFFF));

    START = 1'b1; SIGNED = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    tick();
    START = 1'b0;
    repeat (10) tick();
    RST = 1'b0;
    #1;
    chk("midrst_hi", 64'(HI), 64'd0);
    chk("midrst_lo", 64'(LO), 64'd0);
    chk("midrst_busy", 64'(BUSY), 64'd0);
    repeat (2) tick();
    RST = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DONE || BUSY) saw_done++;
    end
    chk("midrst_quiet", 64'(saw_done), 64'd0);
    run_op("multu_after_rst", 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 0,
           model(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678));

    for (int i = 0; i < 16; i++) begin
      isdiv = 1'($urandom);
      sgn   = 1'($urandom);
      a     = $urandom;
      b     = (i % 4 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i % 4 == 1) b = ~b + 32'd1;
      if (isdiv && b == 32'h0) b = 32'd3;
      run_op("rand", isdiv, sgn, a, b, 0, model(isdiv, sgn, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Multi-cycle multiply/divide unit holding the architectural HI/LO registers. It sits directly downstream of the ALU control decoder and consumes its START/DIV_START/SIGNED/hi_lo_write_en/hi_lo_reg_control outputs. It supplies HI/LO to the mfhi/mflo writeback mux and returns divide_zero to the decoder's exception logic. Iterative radix-2 shift-add multiply and restoring divide, 32 iterations each.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width; holds values 0..WIDTH

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
START  in  1  multiply request (mult/multu)
DIV_START  in  1  divide request (div/divu)
SIGNED  in  1  1 = signed operation, 0 = unsigned
A  in  WIDTH  rs operand: multiplicand / dividend; also the mthi/mtlo data
B  in  WIDTH  rt operand: multiplier / divisor
hi_lo_write_en  in  1  mthi/mtlo write strobe
hi_lo_reg_control  in  1  1 = write HI, 0 = write LO
HI  out  WIDTH  HI register
LO  out  WIDTH  LO register
BUSY  out  1  operation in progress; the multi-cycle FSM stalls on it
DONE  out  1  one-cycle pulse: HI/LO just updated by mult/div
divide_zero  out  1  registered one-cycle pulse: divide by zero rejected

Behaviour:
- Reset (RST low, async): HI=0, LO=0, BUSY=0, DONE=0, divide_zero=0, state IDLE, counter 0. Applies mid-operation: the operation is abandoned and no DONE is issued.
- No combinational path from any input to any output. The decoder gates DIV_START with divide_zero, so divide_zero must be registered.
- States:
  - IDLE: waits for a request.
  - MUL: 32 iterations.
  - DIV: 32 iterations.
  - FIX: 1 cycle for sign correction and HI/LO writeback; always returns to IDLE.
- IDLE request priority: START > DIV_START.
  - START at edge E0: latch |A|, |B| (magnitudes only when SIGNED=1), latch the result sign, go to MUL, BUSY=1 after E0.
  - DIV_START with B==0: do not start; divide_zero=1 for the cycle after the edge; HI/LO unchanged; BUSY stays 0.
  - DIV_START with B!=0: latch as for START, go to DIV.
- Iteration edges E1..E32.
  - MUL: 64-bit shift-add product of the magnitudes.
  - DIV: restoring division, one quotient bit per edge, MSB first.
- E33 (FIX):
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - DONE=1 for exactly one cycle; BUSY=0; state IDLE.
- Latency: HI/LO valid 33 edges after the request edge. The next request is accepted from E34.
- Divide boundaries:
  - Quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0; no exception.
- mthi/mtlo (hi_lo_write_en in IDLE): write A into HI or LO at the edge; the other register is unchanged.
- Simultaneous hi_lo_write_en and START/DIV_START in IDLE: the write occurs and the operation starts; the operation result overwrites both registers at FIX.
- While BUSY (MUL/DIV/FIX):
  - START, DIV_START and hi_lo_write_en are ignored.
  - Operands are taken only from the latched copies, so A/B may change freely.
- HI/LO hold their value in every cycle not listed above.

Decomposition:
- Shared package: WIDTH, the ITER=32 constant, and the state encodings (IDLE, MUL, DIV, FIX), 2-bit.
- One sub-module, mdu_sign_fix: combinational conditional two's-complement negate, instanced for operand magnitude and for result correction.
- FSM, counter, datapath and HI/LO registers stay in mdu_hilo.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges HI=0xFFFFFFFE, LO=0x00000001; one DONE pulse; BUSY high for exactly 33 cycles.
- mult signed 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Division trio:
  - div signed -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 -> LO=3, HI=1.
  - div signed 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- div with B=0, HI/LO preloaded 0x11/0x22 -> divide_zero pulse 1 cycle after the request; BUSY never set; HI=0x11, LO=0x22; no DONE.
- mthi A=0x1234 then mtlo A=0x5678 -> HI=0x1234, LO=0x5678. During a subsequent multu, START and mthi pulses at cycle 5 are ignored and the result is unaffected.
- multu started, RST asserted at iteration 10 -> immediately HI=LO=0, BUSY=0; no DONE after release; a fresh multu completes correctly.
